fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side drain engine for the team's FIFOs. Issues `fifo_rd_en` against a FIFO's `fifo_empty` flag, absorbs the FIFO's one-cycle registered read latency in a 3-entry output buffer, and presents the words as a valid/ready stream. Sustains one word per clock when the FIFO is non-empty and the sink is always ready. Sits between any FIFO read port and a downstream consumer.

## Interface
- `WIDTH`, default 8: data word width.
- `CNT_W`, default 16: width of the delivered-word counter.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `fifo_empty`, in, 1: FIFO empty flag from the FIFO's write/read pointer compare.
- `fifo_rd_en`, out, 1: pop request to the FIFO; one word is returned per asserted cycle.
- `fifo_rdata`, in, WIDTH: FIFO read data, valid in the cycle after `fifo_rd_en`.
- `flush`, in, 1: synchronous discard of all buffered and in-flight words.
- `m_valid`, out, 1: `m_data` holds a word.
- `m_ready`, in, 1: sink accepts the word.
- `m_data`, out, WIDTH: head word of the output buffer.
- `buf_level`, out, 2: buffer occupancy, 0..3.
- `words_out`, out, CNT_W: count of completed stream transfers, wraps modulo 2^CNT_W.

## Operation
- State:
  - 3-entry circular buffer with 2-bit read and write pointers (wrap 2→0).
  - `occ` (0..3).
  - `inflight`, 1 bit: registered copy of `fifo_rd_en`.
  - `words_out`.
- Issue rule (combinational):
  - `fifo_rd_en = !fifo_empty && !flush && (occ + inflight) < 3`.
  - `m_ready` must not appear in this path.
- Arrival: when `inflight` is 1 and `flush` is 0, capture `fifo_rdata` at the write pointer and advance the write pointer.
- Pop:
  - A transfer occurs when `m_valid && m_ready`. It advances the read pointer and increments `words_out`.
  - `m_valid = (occ != 0)`.
  - `m_data` is the entry at the read pointer, registered storage with no bypass.
- Occupancy: `occ_next = occ + arrival - pop`. Arrival and pop in the same cycle leave `occ` unchanged.
- The credit rule guarantees that an arrival never meets a full buffer. Overflow is a design error; flag it with an assertion.
- Flush:
  - In the flush cycle, no `fifo_rd_en` is issued.
  - An arriving word in the flush cycle is discarded.
  - On the next edge, `occ`, both pointers and `inflight` clear.
  - `words_out` is unaffected.
  - A pop in the flush cycle still counts if `m_valid && m_ready`.
- `m_data` must be held stable while `m_valid && !m_ready`.

## Timing
- Reset values:
  - `fifo_rd_en` = 0 while reset is asserted, independent of `fifo_empty`.
  - `m_valid` = 0, `buf_level` = 0, `words_out` = 0.
  - `m_data` = 0, with the buffer contents cleared.
  - `inflight` = 0 and both pointers = 0.
- Latency, from `fifo_rd_en` (cycle t) to `m_valid` high: `fifo_rdata` is captured at the end of t+1, so `m_valid` is first high in t+2.
- Throughput:
  - The steady state is `occ` = 1 and `inflight` = 1, giving 1 word per cycle.
  - With `m_ready` held low, at most 3 words are pulled, then `fifo_rd_en` stays low.
- Resume after a stall: the first pop frees a credit. `fifo_rd_en` reasserts in the next cycle, which has `occ` = 2.
- `fifo_empty` rises mid-burst: issue stops immediately, and any in-flight word is still captured.
- Reset mid-operation clears everything asynchronously. A FIFO word in flight at reset is lost by design.
- `buf_level` is the registered `occ`.

## Structure
- Shared package `fifo_pkg` holds:
  - `OBUF_DEPTH = 3`
  - `OBUF_PTR_W = 2`
  - a `ptr_t` typedef, reused by the FIFO blocks for pointer math.
- Sub-module `fifo_rd_obuf`: the 3-entry circular buffer, with push/pop/clear and head/occ outputs.
- The top level holds the issue/credit logic, `inflight`, flush and `words_out`.

## Test plan
- Reset, then back-to-back words with `m_ready` = 1:
  - Feed the FIFO model with 0x11, 0x22, 0x33, 0x44 and hold `fifo_empty` low.
  - Required: `fifo_rd_en` in cycles 0–3, `m_valid` high in cycles 2–5 with data in order, and `words_out` = 4.
- Backpressure:
  - Hold `m_ready` = 0 with 6 words available.
  - Required: exactly 3 `fifo_rd_en` pulses, `buf_level` = 3, and `m_data` stable at the first word.
  - Release `m_ready`: all 6 words emerge in order.
- Empty mid-burst: raise `fifo_empty` after 2 issues.
  - Required: no further `fifo_rd_en`, both words delivered, and `m_valid` low afterward.
- Flush with one word in flight and 2 words buffered:
  - Required: the next cycle shows `m_valid` = 0 and `buf_level` = 0.
  - Required: the in-flight word never appears, and `words_out` is unchanged.
- Random `m_ready` (50%) over 1000 words with random `fifo_empty`:
  - Required: in-order, lossless delivery.
  - Required: `words_out` = 1000 mod 2^CNT_W.
  - Required: the buffer-overflow assertion never fires.
- Reset asserted with 2 words buffered:
  - Required: all outputs reach reset values immediately.
  - Required: the first post-reset word is the next FIFO entry.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: output-buffer geometry and pointer math.
// Used by the FIFO read-side blocks.
package fifo_pkg;

  localparam int OBUF_DEPTH = 3;
  localparam int OBUF_PTR_W = 2;

  typedef logic [OBUF_PTR_W-1:0] ptr_t;

  // The depth is not a power of two, so the pointer wraps explicitly.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// 3-entry circular output buffer for the FIFO read path.
// Provides push/pop/clear and exposes the head word and the occupancy.
module fifo_rd_obuf
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output ptr_t             occ
);

  logic [WIDTH-1:0] mem [OBUF_DEPTH];
  ptr_t wr_ptr;
  ptr_t rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < OBUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + ptr_t'(push) - ptr_t'(pop);
    end
  end

  assign head = mem[rd_ptr];

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(push && !clear && occ == ptr_t'(OBUF_DEPTH)));

  a_no_underflow: assert property (
    @(posedge clk) disable iff (reset)
    !(pop && !clear && occ == '0));

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-side drain engine: credit-based pop issue, one-cycle
// read latency absorbed in a 3-entry buffer, valid/ready output.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       buf_level,
  output logic [CNT_W-1:0] words_out
);

  ptr_t       occ;
  logic       inflight;
  logic       arrive;
  logic       pop;
  logic [2:0] credit;

  // Buffered plus in-flight words must fit; m_ready stays out of this path.
  assign credit     = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = !reset && !fifo_empty && !flush
                      && (credit < 3'(OBUF_DEPTH));

  assign m_valid   = (occ != '0);
  assign pop       = m_valid && m_ready;
  assign arrive    = inflight && !flush;
  assign buf_level = occ;

  fifo_rd_obuf #(
    .WIDTH(WIDTH)
  ) u_obuf (
    .clk      (clk),
    .reset    (reset),
    .push     (arrive),
    .push_data(fifo_rdata),
    .pop      (pop),
    .clear    (flush),
    .head     (m_data),
    .occ      (occ)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) inflight <= 1'b0;
    else       inflight <= fifo_rd_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    words_out <= '0;
    else if (pop) words_out <= words_out + 1'b1;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, word-order scoreboard,
// directed scenarios and a randomized drain run.
module tb_fifo_stream_reader;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rdata;
  logic             flush;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       buf_level;
  logic [CNT_W-1:0] words_out;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rdata(fifo_rdata),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .buf_level (buf_level),
    .words_out (words_out)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] src_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int               infl;
  int               n_del;
  int               n_rd;
  logic [CNT_W-1:0] cnt_model;
  logic [WIDTH-1:0] last_out;
  bit               last_rd;
  bit               last_valid;
  bit               drv_ready;
  bit               drv_flush;
  bit               drv_force;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock: drive at negedge, predict and score at negedge+1,
  // return FIFO read data just after the rising edge.
  task automatic step();
    logic [WIDTH-1:0] w;
    bit rd;
    bit tx;
    int lvl;
    @(negedge clk);
    m_ready    = drv_ready;
    flush      = drv_flush;
    fifo_empty = drv_force || (src_q.size() == 0);
    #1;
    lvl = exp_q.size() - infl;
    chk("buf_level", 32'(buf_level), 32'(lvl));
    chk("m_valid", 32'(m_valid), 32'(lvl != 0));
    chk("rd_en", 32'(fifo_rd_en),
        32'(!fifo_empty && !flush && exp_q.size() < 3));
    rd = fifo_rd_en;
    tx = m_valid && m_ready;
    last_rd    = rd;
    last_valid = m_valid;
    if (tx && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("m_data", 32'(m_data), 32'(w));
      last_out = w;
      n_del++;
      cnt_model++;
    end
    if (flush) exp_q.delete();
    w = WIDTH'($urandom);
    if (rd && src_q.size() > 0) begin
      w = src_q.pop_front();
      exp_q.push_back(w);
      n_rd++;
    end
    infl = rd ? 1 : 0;
    @(posedge clk);
    #1;
    fifo_rdata = w;
    chk("words_out", 32'(words_out), 32'(cnt_model));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    fifo_empty = 1'b0;
    reset      = 1'b1;
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_buf_level", 32'(buf_level), 32'd0);
    chk("rst_words_out", 32'(words_out), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    exp_q.delete();
    infl      = 0;
    cnt_model = '0;
    @(negedge clk);
    fifo_empty = 1'b1;
    flush      = 1'b0;
    reset      = 1'b0;
  endtask

  initial begin
    int base_rd;
    int base_del;
    int budget;
    logic [7:0] rd_mask;
    logic [7:0] val_mask;
    logic [CNT_W-1:0] w0;

    reset      = 1'b1;
    fifo_empty = 1'b1;
    flush      = 1'b0;
    m_ready    = 1'b0;
    fifo_rdata = '0;
    infl       = 0;
    n_del      = 0;
    n_rd       = 0;
    cnt_model  = '0;
    last_out   = '0;
    drv_ready  = 1'b0;
    drv_flush  = 1'b0;
    drv_force  = 1'b0;
    do_reset();

    // Back-to-back with an always-ready sink
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    drv_ready = 1'b1;
    rd_mask  = '0;
    val_mask = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      rd_mask[i]  = last_rd;
      val_mask[i] = last_valid;
    end
    chk("b2b_rd_cycles", 32'(rd_mask), 32'h0f);
    chk("b2b_valid_cycles", 32'(val_mask), 32'h3c);
    chk("b2b_words_out", 32'(words_out), 32'd4);
    chk("b2b_last", 32'(last_out), 32'h44);

    // Backpressure
    src_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    drv_ready = 1'b0;
    base_rd = n_rd;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i >= 3) chk("bp_hold_data", 32'(m_data), 32'hA0);
    end
    chk("bp_rd_pulses", 32'(n_rd - base_rd), 32'd3);
    chk("bp_level", 32'(buf_level), 32'd3);
    drv_ready = 1'b1;
    base_del = n_del;
    budget = 0;
    while (n_del - base_del < 6 && budget < 40) begin
      step();
      budget++;
    end
    chk("bp_delivered", 32'(n_del - base_del), 32'd6);
    chk("bp_last", 32'(last_out), 32'hA5);

    // Empty rises mid-burst
    src_q = '{8'h51, 8'h52, 8'h53, 8'h54};
    base_rd  = n_rd;
    base_del = n_del;
    step();
    step();
    drv_force = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("emp_rd_pulses", 32'(n_rd - base_rd), 32'd2);
    chk("emp_delivered", 32'(n_del - base_del), 32'd2);
    chk("emp_valid_low", 32'(m_valid), 32'd0);
    src_q.delete();
    drv_force = 1'b0;

    // Flush with two buffered and one in flight
    src_q = '{8'h61, 8'h62, 8'h63};
    drv_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("fl_pre_level", 32'(buf_level), 32'd2);
    w0 = words_out;
    drv_flush = 1'b1;
    step();
    drv_flush = 1'b0;
    chk("fl_valid", 32'(m_valid), 32'd0);
    chk("fl_level", 32'(buf_level), 32'd0);
    chk("fl_words_out", 32'(words_out), 32'(w0));
    src_q = '{8'h5A};
    drv_ready = 1'b1;
    base_del = n_del;
    for (int i = 0; i < 5; i++) step();
    chk("fl_next_word", 32'(last_out), 32'h5A);
    chk("fl_next_count", 32'(n_del - base_del), 32'd1);

    // Random sink readiness and FIFO emptiness
    for (int i = 0; i < 1000; i++) src_q.push_back(WIDTH'($urandom));
    w0 = words_out;
    base_del = n_del;
    budget = 0;
    while (n_del - base_del < 1000 && budget < 20000) begin
      drv_ready = 1'($urandom_range(0, 1));
      drv_force = ($urandom_range(0, 3) == 0);
      step();
      budget++;
    end
    chk("rnd_delivered", 32'(n_del - base_del), 32'd1000);
    chk("rnd_words_out", 32'(CNT_W'(words_out - w0)), 32'd1000);
    drv_force = 1'b0;

    // Reset with two words buffered
    src_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    drv_ready = 1'b0;
    step();
    step();
    drv_force = 1'b1;
    step();
    step();
    chk("rst_pre_level", 32'(buf_level), 32'd2);
    do_reset();
    drv_force = 1'b0;
    drv_ready = 1'b1;
    base_del = n_del;
    budget = 0;
    while (n_del == base_del && budget < 20) begin
      step();
      budget++;
    end
    chk("rst_first_word", 32'(last_out), 32'hC3);
    for (int i = 0; i < 4; i++) step();
    chk("rst_after_count", 32'(words_out), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
